// File: rtl/mem_stage.sv
// MEM pipeline stage and MEM/WB register: ALU results pass through in one cycle,
// LW/SW run a req/ack access to data SRAM while holding upstream via stallreq_o.
module mem_stage #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned REG_W   = 4,
  parameter logic [2:0]  OP_LW   = 3'b101,
  parameter logic [2:0]  OP_SW   = 3'b110,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        aluop_i,
  input  logic              we_i,
  input  logic [REG_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] sdata_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              we_o,
  output logic [REG_W-1:0]  waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              stallreq_o,
  output logic              err_o,
  output logic              ram_req_o,
  output logic              ram_we_o,
  output logic [DATA_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic              ram_ack_i,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_lw;
  logic               lat_we;
  logic [REG_W-1:0]   lat_waddr;
  logic               flushed;
  logic               aborted;
  logic [DATA_W-1:0]  result;
  logic               is_mem;

  assign is_mem = (aluop_i == OP_LW) || (aluop_i == OP_SW);

  // Hold upstream while a memory op is being issued or is in flight.
  assign stallreq_o = rst & (((state == IDLE) & is_mem & ~flush_i) | (state == ACCESS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      is_lw       <= 1'b0;
      lat_we      <= 1'b0;
      lat_waddr   <= '0;
      flushed     <= 1'b0;
      aborted     <= 1'b0;
      result      <= '0;
      we_o        <= 1'b0;
      waddr_o     <= '0;
      wdata_o     <= '0;
      err_o       <= 1'b0;
      ram_req_o   <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
    end else if (!stall_i) begin
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (is_mem && !flush_i) begin
            state       <= ACCESS;
            ram_req_o   <= 1'b1;
            ram_we_o    <= (aluop_i == OP_SW);
            ram_addr_o  <= wdata_i;
            ram_wdata_o <= sdata_i;
            is_lw       <= (aluop_i == OP_LW);
            lat_we      <= we_i;
            lat_waddr   <= waddr_i;
            flushed     <= 1'b0;
            aborted     <= 1'b0;
            cnt         <= '0;
            we_o        <= 1'b0;
          end else begin
            we_o    <= we_i & ~flush_i;
            waddr_o <= waddr_i;
            wdata_o <= wdata_i;
          end
        end
        ACCESS: begin
          if (flush_i) flushed <= 1'b1;
          cnt <= cnt + CNT_W'(1);
          // An ack on the expiry cycle still completes the access normally.
          if (ram_ack_i) begin
            ram_req_o <= 1'b0;
            state     <= DONE;
            if (is_lw) result <= ram_rdata_i;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            ram_req_o <= 1'b0;
            err_o     <= 1'b1;
            aborted   <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (is_lw) begin
            we_o    <= lat_we & ~aborted & ~flushed & ~flush_i;
            waddr_o <= lat_waddr;
            wdata_o <= result;
          end else begin
            we_o <= 1'b0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: transaction-level reference model checked every cycle,
// an SRAM responder with programmable ack delay, and literal spot checks.
module tb_mem_stage;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned REG_W   = 4;
  localparam int          TIMEOUT = 15;
  localparam logic [2:0]  OP_ALU  = 3'b000;
  localparam logic [2:0]  OP_LW   = 3'b101;
  localparam logic [2:0]  OP_SW   = 3'b110;

  logic              clk, rst;
  logic [2:0]        aluop_i;
  logic              we_i;
  logic [REG_W-1:0]  waddr_i;
  logic [DATA_W-1:0] wdata_i, sdata_i;
  logic              stall_i, flush_i;
  logic              we_o;
  logic [REG_W-1:0]  waddr_o;
  logic [DATA_W-1:0] wdata_o;
  logic              stallreq_o, err_o;
  logic              ram_req_o, ram_we_o;
  logic [DATA_W-1:0] ram_addr_o, ram_wdata_o;
  logic              ram_ack_i;
  logic [DATA_W-1:0] ram_rdata_i;

  mem_stage dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .we_i(we_i), .waddr_i(waddr_i),
    .wdata_i(wdata_i), .sdata_i(sdata_i), .stall_i(stall_i), .flush_i(flush_i),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o),
    .err_o(err_o), .ram_req_o(ram_req_o), .ram_we_o(ram_we_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_ack_i(ram_ack_i), .ram_rdata_i(ram_rdata_i)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM responder: acks ack_delay cycles after the request rises (0 = never).
  logic [15:0] sram    [0:255];
  logic [15:0] exp_mem [0:255];
  int  ack_delay = 1;
  int  wait_cnt  = 0;
  bit  ack_sent  = 0;
  bit  force_ack = 0;
  int  req_cnt   = 0;
  int  err_cnt   = 0;

  always @(negedge clk) begin
    ram_ack_i = force_ack;
    if (ram_req_o) req_cnt++;
    if (err_o) err_cnt++;
    if (!ram_req_o) begin
      wait_cnt = 0;
      ack_sent = 0;
    end else if (!ack_sent) begin
      wait_cnt++;
      if (ack_delay > 0 && wait_cnt == ack_delay) begin
        ram_ack_i   = 1'b1;
        ack_sent    = 1;
        ram_rdata_i = sram[ram_addr_o[7:0]];
        if (ram_we_o) sram[ram_addr_o[7:0]] = ram_wdata_o;
      end
    end
  end

  // Reference model: one outstanding transaction, resolved by ack or by age reaching TIMEOUT.
  bit          busy, resolved, t_lw, t_we, t_flushed, t_aborted;
  int          age;
  logic [3:0]  t_waddr;
  logic [15:0] t_data;
  logic        m_we, m_err, m_req, m_rwe, m_stallreq;
  logic [3:0]  m_waddr;
  logic [15:0] m_wdata, m_raddr, m_rwdata;

  always @(posedge clk) begin
    if (!rst) begin
      busy = 0; resolved = 0; age = 0;
      m_we = 0; m_waddr = '0; m_wdata = '0; m_err = 0;
      m_req = 0; m_rwe = 0; m_raddr = '0; m_rwdata = '0;
    end else if (!stall_i) begin
      m_err = 0;
      if (!busy) begin
        if ((aluop_i == OP_LW || aluop_i == OP_SW) && !flush_i) begin
          busy = 1; resolved = 0; age = 0;
          t_lw = (aluop_i == OP_LW); t_we = we_i; t_waddr = waddr_i;
          t_flushed = 0; t_aborted = 0;
          m_req = 1; m_rwe = (aluop_i == OP_SW); m_raddr = wdata_i; m_rwdata = sdata_i;
          m_we = 0;
        end else begin
          m_we = we_i & ~flush_i; m_waddr = waddr_i; m_wdata = wdata_i;
        end
      end else if (!resolved) begin
        if (flush_i) t_flushed = 1;
        age++;
        if (ram_ack_i) begin
          resolved = 1; m_req = 0;
          if (t_lw) t_data = exp_mem[m_raddr[7:0]];
          else exp_mem[m_raddr[7:0]] = m_rwdata;
        end else if (age == TIMEOUT) begin
          resolved = 1; t_aborted = 1; m_req = 0; m_err = 1;
        end
      end else begin
        if (flush_i) t_flushed = 1;
        if (t_lw) begin
          m_we = t_we & ~t_aborted & ~t_flushed; m_waddr = t_waddr; m_wdata = t_data;
        end else begin
          m_we = 0;
        end
        busy = 0;
      end
    end
    #1;
    m_stallreq = rst && ((!busy && (aluop_i == OP_LW || aluop_i == OP_SW) && !flush_i)
                         || (busy && !resolved));
    check("we_o", we_o, m_we);
    if (m_we) begin
      check("waddr_o", waddr_o, m_waddr);
      check("wdata_o", wdata_o, m_wdata);
    end
    check("err_o", err_o, m_err);
    check("ram_req_o", ram_req_o, m_req);
    if (m_req) begin
      check("ram_we_o", ram_we_o, m_rwe);
      check("ram_addr_o", ram_addr_o, m_raddr);
      check("ram_wdata_o", ram_wdata_o, m_rwdata);
    end
    check("stallreq_o", stallreq_o, m_stallreq);
  end

  task automatic present(input logic [2:0] op, input logic we, input logic [3:0] wa,
                         input logic [15:0] wd, input logic [15:0] sd, input logic fl);
    aluop_i = op; we_i = we; waddr_i = wa; wdata_i = wd; sdata_i = sd; flush_i = fl;
  endtask

  task automatic alu(input logic we, input logic [3:0] wa, input logic [15:0] wd, input logic fl);
    present(OP_ALU, we, wa, wd, 16'h0000, fl);
    @(negedge clk);
  endtask

  // Present a memory op and hold it until the stage releases upstream; n = stalled negedges + 1.
  task automatic mem_op(input logic [2:0] op, input logic [3:0] wa, input logic [15:0] addr,
                        input logic [15:0] sd, input int delay, output int n);
    ack_delay = delay;
    req_cnt = 0;
    present(op, 1'b1, wa, addr, sd, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stallreq_o && n < 40);
    check("mem_op_bounded", 32'(n < 40), 32'd1);
    @(negedge clk);
  endtask

  int n, e0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i]    = 16'(i * 16'h0101 + 16'h1000);
      exp_mem[i] = sram[i];
    end
    sram[8'h40] = 16'hBEEF; exp_mem[8'h40] = 16'hBEEF;
    sram[8'h20] = 16'h5A5A; exp_mem[8'h20] = 16'h5A5A;
    rst = 1'b0; stall_i = 1'b0;
    present(OP_ALU, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0);
    ram_ack_i = 1'b0; ram_rdata_i = '0;
    repeat (3) @(negedge clk);
    check("rst_we", we_o, 1'b0);
    check("rst_req", ram_req_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    // ALU pass-through, flushed ALU op, non-writing ALU op
    alu(1'b1, 4'h1, 16'h0009, 1'b0);
    check("alu_we", we_o, 1'b1);
    check("alu_waddr", waddr_o, 4'h1);
    check("alu_wdata", wdata_o, 16'h0009);
    alu(1'b1, 4'h2, 16'h1111, 1'b1);
    check("alu_flush_we", we_o, 1'b0);
    alu(1'b0, 4'h7, 16'h2222, 1'b0);

    // LW, ack two cycles after request
    mem_op(OP_LW, 4'h3, 16'h0040, 16'h0000, 2, n);
    check("lw_stall_len", n, 3);
    check("lw_req_cycles", req_cnt, 2);
    check("lw_we", we_o, 1'b1);
    check("lw_waddr", waddr_o, 4'h3);
    check("lw_wdata", wdata_o, 16'hBEEF);

    // SW then LW of the same word, zero-wait SRAM
    e0 = err_cnt;
    mem_op(OP_SW, 4'h4, 16'h0010, 16'h807F, 1, n);
    check("sw_we", we_o, 1'b0);
    check("sw_no_err", err_cnt, e0);
    mem_op(OP_LW, 4'h5, 16'h0010, 16'h0000, 1, n);
    check("zero_wait_len", n, 2);
    check("lw_after_sw", wdata_o, 16'h807F);

    // Timeout: no ack
    e0 = err_cnt;
    mem_op(OP_LW, 4'h6, 16'h0030, 16'h0000, 0, n);
    check("to_len", n, 16);
    check("to_req_cycles", req_cnt, 15);
    check("to_err_pulses", err_cnt - e0, 1);
    check("to_we", we_o, 1'b0);
    alu(1'b1, 4'h8, 16'h0ABC, 1'b0);
    check("to_idle_after", wdata_o, 16'h0ABC);

    // Ack on the expiry cycle wins
    e0 = err_cnt;
    mem_op(OP_LW, 4'h9, 16'h0020, 16'h0000, 15, n);
    check("edge_no_err", err_cnt, e0);
    check("edge_we", we_o, 1'b1);
    check("edge_wdata", wdata_o, 16'h5A5A);

    // Flush mid-access: request held until ack, result discarded
    ack_delay = 4; req_cnt = 0;
    present(OP_LW, 1'b1, 4'hA, 16'h0041, 16'h0000, 1'b0);
    @(negedge clk); flush_i = 1'b1;
    @(negedge clk); flush_i = 1'b0;
    n = 0;
    while (stallreq_o && n < 40) begin @(negedge clk); n++; end
    check("flush_bounded", 32'(n < 40), 32'd1);
    @(negedge clk);
    check("flush_req_cycles", req_cnt, 4);
    check("flush_we", we_o, 1'b0);

    // Memory op flushed in IDLE issues nothing
    present(OP_LW, 1'b1, 4'hB, 16'h0042, 16'h0000, 1'b1);
    @(negedge clk);
    check("idle_flush_req", ram_req_o, 1'b0);
    check("idle_flush_we", we_o, 1'b0);

    // Stray ack in IDLE is ignored
    alu(1'b1, 4'h2, 16'h0AAA, 1'b0);
    force_ack = 1;
    repeat (2) @(negedge clk);
    force_ack = 0;
    @(negedge clk);
    check("stray_req", ram_req_o, 1'b0);
    check("stray_stall", stallreq_o, 1'b0);

    // Stall freezes the MEM/WB register
    stall_i = 1'b1;
    present(OP_ALU, 1'b1, 4'h5, 16'h1234, 16'h0000, 1'b0);
    repeat (2) @(negedge clk);
    check("stall_hold", wdata_o, 16'h0AAA);
    stall_i = 1'b0;
    @(negedge clk);
    check("stall_release", wdata_o, 16'h1234);

    // Reset mid-access
    ack_delay = 0;
    present(OP_LW, 1'b1, 4'hC, 16'h0050, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_req", ram_req_o, 1'b0);
    check("mid_rst_stall", stallreq_o, 1'b0);
    check("mid_rst_we", we_o, 1'b0);
    @(negedge clk);
    present(OP_ALU, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    alu(1'b1, 4'hD, 16'h7777, 1'b0);
    check("post_rst_alu", wdata_o, 16'h7777);
    mem_op(OP_LW, 4'hE, 16'h0040, 16'h0000, 1, n);
    check("post_rst_lw", wdata_o, 16'hBEEF);
    check("post_rst_waddr", waddr_o, 4'hE);

    alu(1'b0, 4'h0, 16'h0000, 1'b0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 time units");
    $fatal(1);
  end

endmodule
